// File: rtl/rtc_bus_sequencer.sv
// Arbitrates config-FSM writes and VGA reads onto the multiplexed RTC parallel port.
// One registered bus cycle per grant: ADDR -> AHOLD -> DATA -> DHOLD -> DONE.
module rtc_bus_sequencer #(
    parameter int PULSE_CYC = 4,
    parameter int GAP_CYC   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    input  logic       rd_req,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       rd_ack,
    output logic       busy,
    output logic       sel_wr,
    output logic       sel_rd,
    output logic       rtc_cs_n,
    output logic       rtc_ad,
    output logic       rtc_wr_n,
    output logic       rtc_rd_n,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_AHOLD, S_DATA, S_DHOLD, S_DONE
    } state_t;

    localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
    localparam logic [7:0] GAP_LD   = 8'(GAP_CYC - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       is_wr_q, is_wr_d;
    logic       last_wr_q, last_wr_d;
    logic [7:0] addr_q, addr_d, data_q, data_d;
    logic [7:0] rd_data_q, rd_data_d;

    logic       cs_n_q, cs_n_d, ad_sel_q, ad_sel_d;
    logic       wr_n_q, wr_n_d, rd_n_q, rd_n_d, oe_q, oe_d;
    logic [7:0] ad_out_q, ad_out_d;
    logic       wr_ack_q, wr_ack_d, rd_ack_q, rd_ack_d;
    logic       busy_q, busy_d, sel_wr_q, sel_wr_d, sel_rd_q, sel_rd_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_wr_d   = is_wr_q;
        last_wr_d = last_wr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rd_data_d = rd_data_q;

        case (state_q)
            S_IDLE: begin
                if (wr_req || rd_req) begin
                    // On a tie, the type not granted last time wins.
                    is_wr_d   = wr_req && !(rd_req && last_wr_q);
                    last_wr_d = is_wr_d;
                    addr_d    = is_wr_d ? wr_addr : rd_addr;
                    data_d    = wr_data;
                    cnt_d     = PULSE_LD;
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_AHOLD;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_AHOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_DATA;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == 8'd0) begin
                    if (!is_wr_q) rd_data_d = ad_in;
                    state_d = S_DHOLD;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DHOLD: begin
                if (cnt_q == 8'd0) state_d = S_DONE;
                else               cnt_d   = cnt_q - 8'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so every pin comes straight off a flop.
        cs_n_d   = 1'b1;
        ad_sel_d = 1'b0;
        wr_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        oe_d     = 1'b0;
        ad_out_d = 8'h00;
        busy_d   = (state_d != S_IDLE);
        sel_wr_d = busy_d && is_wr_d;
        sel_rd_d = busy_d && !is_wr_d;
        wr_ack_d = (state_d == S_DONE) && is_wr_d;
        rd_ack_d = (state_d == S_DONE) && !is_wr_d;

        case (state_d)
            S_ADDR: begin
                cs_n_d = 1'b0; wr_n_d = 1'b0; oe_d = 1'b1; ad_out_d = addr_d;
            end
            S_AHOLD: begin
                cs_n_d = 1'b0; oe_d = 1'b1; ad_out_d = addr_d;
            end
            S_DATA: begin
                cs_n_d = 1'b0; ad_sel_d = 1'b1;
                if (is_wr_d) begin
                    wr_n_d = 1'b0; oe_d = 1'b1; ad_out_d = data_d;
                end else begin
                    rd_n_d = 1'b0;
                end
            end
            S_DHOLD: begin
                cs_n_d = 1'b0; ad_sel_d = 1'b1;
                if (is_wr_d) begin
                    oe_d = 1'b1; ad_out_d = data_d;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            is_wr_q   <= 1'b0;
            last_wr_q <= 1'b0;
            addr_q    <= 8'h00;
            data_q    <= 8'h00;
            rd_data_q <= 8'h00;
            cs_n_q    <= 1'b1;
            ad_sel_q  <= 1'b0;
            wr_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            oe_q      <= 1'b0;
            ad_out_q  <= 8'h00;
            wr_ack_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            busy_q    <= 1'b0;
            sel_wr_q  <= 1'b0;
            sel_rd_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_wr_q   <= is_wr_d;
            last_wr_q <= last_wr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rd_data_q <= rd_data_d;
            cs_n_q    <= cs_n_d;
            ad_sel_q  <= ad_sel_d;
            wr_n_q    <= wr_n_d;
            rd_n_q    <= rd_n_d;
            oe_q      <= oe_d;
            ad_out_q  <= ad_out_d;
            wr_ack_q  <= wr_ack_d;
            rd_ack_q  <= rd_ack_d;
            busy_q    <= busy_d;
            sel_wr_q  <= sel_wr_d;
            sel_rd_q  <= sel_rd_d;
        end
    end

    assign rtc_cs_n = cs_n_q;
    assign rtc_ad   = ad_sel_q;
    assign rtc_wr_n = wr_n_q;
    assign rtc_rd_n = rd_n_q;
    assign ad_oe    = oe_q;
    assign ad_out   = ad_out_q;
    assign wr_ack   = wr_ack_q;
    assign rd_ack   = rd_ack_q;
    assign rd_data  = rd_data_q;
    assign busy     = busy_q;
    assign sel_wr   = sel_wr_q;
    assign sel_rd   = sel_rd_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: default-timing instance plus a PULSE_CYC=1/GAP_CYC=1 instance,
// checked cycle by cycle against a phase-length model of the bus transaction.
module tb_rtc_bus_sequencer;

    localparam int P = 4, G = 2, L = 2*P + 2*G + 1;
    localparam logic [14:0] IDLE_V = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       wr_req, rd_req, wr_ack, rd_ack, busy, sel_wr, sel_rd;
    logic       rtc_cs_n, rtc_ad, rtc_wr_n, rtc_rd_n, ad_oe;
    logic [7:0] wr_addr, wr_data, rd_addr, rd_data, ad_out, ad_in;

    logic       wr_req1, rd_req1, wr_ack1, rd_ack1, busy1, sel_wr1, sel_rd1;
    logic       rtc_cs_n1, rtc_ad1, rtc_wr_n1, rtc_rd_n1, ad_oe1;
    logic [7:0] wr_addr1, wr_data1, rd_addr1, rd_data1, ad_out1, ad_in1;

    rtc_bus_sequencer dut (
        .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ack(rd_ack),
        .busy(busy), .sel_wr(sel_wr), .sel_rd(sel_rd), .rtc_cs_n(rtc_cs_n), .rtc_ad(rtc_ad),
        .rtc_wr_n(rtc_wr_n), .rtc_rd_n(rtc_rd_n), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
    );

    rtc_bus_sequencer #(.PULSE_CYC(1), .GAP_CYC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_req(wr_req1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .wr_ack(wr_ack1), .rd_req(rd_req1), .rd_addr(rd_addr1), .rd_data(rd_data1), .rd_ack(rd_ack1),
        .busy(busy1), .sel_wr(sel_wr1), .sel_rd(sel_rd1), .rtc_cs_n(rtc_cs_n1), .rtc_ad(rtc_ad1),
        .rtc_wr_n(rtc_wr_n1), .rtc_rd_n(rtc_rd_n1), .ad_out(ad_out1), .ad_oe(ad_oe1), .ad_in(ad_in1)
    );

    logic [14:0] obs, obs1;
    assign obs  = {rtc_cs_n, rtc_ad, rtc_wr_n, rtc_rd_n, ad_oe, ad_out, wr_ack, rd_ack};
    assign obs1 = {rtc_cs_n1, rtc_ad1, rtc_wr_n1, rtc_rd_n1, ad_oe1, ad_out1, wr_ack1, rd_ack1};

    int total = 0, bad = 0;
    bit last_m;  // model: 1 = last grant was a write

    // Expected pins in cycle i (1 = first cycle after the grant edge) of a transaction.
    function automatic logic [14:0] bus_exp(int i, bit wr, logic [7:0] a, logic [7:0] d, int pc, int gc);
        logic cs_n, adp, wn, rn, oe, wa, ra;
        logic [7:0] o;
        cs_n = 1; adp = 0; wn = 1; rn = 1; oe = 0; o = 8'h00; wa = 0; ra = 0;
        if (i <= pc) begin
            cs_n = 0; wn = 0; oe = 1; o = a;
        end else if (i <= pc + gc) begin
            cs_n = 0; oe = 1; o = a;
        end else if (i <= 2*pc + gc) begin
            cs_n = 0; adp = 1;
            if (wr) begin wn = 0; oe = 1; o = d; end
            else rn = 0;
        end else if (i <= 2*pc + 2*gc) begin
            cs_n = 0; adp = 1;
            if (wr) begin oe = 1; o = d; end
        end else begin
            wa = wr; ra = !wr;
        end
        return {cs_n, adp, wn, rn, oe, o, wa, ra};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_m = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        wr_req = 0; rd_req = 0; wr_addr = 0; wr_data = 0; rd_addr = 0; ad_in = 0;
        wr_req1 = 0; rd_req1 = 0; wr_addr1 = 0; wr_data1 = 0; rd_addr1 = 0; ad_in1 = 0;
        #1 rst_n = 1'b0;
        #2;
        total++; if (obs !== IDLE_V) begin bad++; $display("FAIL reset_bus got=%h exp=%h", obs, IDLE_V); end
        total++; if ({busy, sel_wr, sel_rd, rd_data} !== 11'h0) begin
            bad++; $display("FAIL reset_status got=%h exp=0", {busy, sel_wr, sel_rd, rd_data}); end
        total++; if (obs1 !== IDLE_V) begin bad++; $display("FAIL reset_bus1 got=%h exp=%h", obs1, IDLE_V); end
        last_m = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        logic [7:0] a = 8'h21, d = 8'h45;
        logic [14:0] e;
        wr_addr = a; wr_data = d; wr_req = 1;
        for (int i = 1; i <= L; i++) begin
            @(posedge clk); @(negedge clk);
            if (i == 1) begin wr_addr = ~a; wr_data = ~d; end
            e = bus_exp(i, 1'b1, a, d, P, G);
            total++; if (obs !== e) begin bad++; $display("FAIL write_bus c%0d got=%h exp=%h", i, obs, e); end
            total++; if ({busy, sel_wr, sel_rd} !== 3'b110) begin
                bad++; $display("FAIL write_sel c%0d got=%b exp=110", i, {busy, sel_wr, sel_rd}); end
            if (i == L) wr_req = 0;
        end
        last_m = 1'b1;
        @(posedge clk); @(negedge clk);
        total++; if ({busy, sel_wr, obs} !== {2'b00, IDLE_V}) begin
            bad++; $display("FAIL write_idle got=%h exp=%h", {busy, sel_wr, obs}, {2'b00, IDLE_V}); end
    endtask

    task automatic test_read();
        logic [7:0] a = 8'h22;
        logic [14:0] e;
        rd_addr = a; ad_in = 8'h59; rd_req = 1;
        for (int i = 1; i <= L; i++) begin
            @(posedge clk); @(negedge clk);
            e = bus_exp(i, 1'b0, a, 8'h00, P, G);
            total++; if (obs !== e) begin bad++; $display("FAIL read_bus c%0d got=%h exp=%h", i, obs, e); end
            total++; if ({busy, sel_wr, sel_rd} !== 3'b101) begin
                bad++; $display("FAIL read_sel c%0d got=%b exp=101", i, {busy, sel_wr, sel_rd}); end
            if (i == L) begin
                total++; if (rd_data !== 8'h59) begin bad++; $display("FAIL read_data got=%h exp=59", rd_data); end
                rd_req = 0;
                ad_in = 8'hA6;
            end
        end
        last_m = 1'b0;
        repeat (3) @(negedge clk);
        total++; if ({busy, rd_data} !== {1'b0, 8'h59}) begin
            bad++; $display("FAIL read_hold got=%h exp=059", {busy, rd_data}); end
    endtask

    task automatic test_tie();
        bit first_wr;
        int ws = 0, rs = 0, wa = 0, ra = 0, ews, ers;
        do_reset();
        first_wr = !last_m;
        wr_addr = 8'($urandom); wr_data = 8'($urandom); rd_addr = 8'($urandom);
        wr_req = 1; rd_req = 1;
        for (int n = 1; n <= 60 && (wa == 0 || ra == 0); n++) begin
            @(posedge clk); @(negedge clk);
            total++; if (sel_wr && sel_rd) begin bad++; $display("FAIL tie_overlap c%0d got=11 exp=not both", n); end
            if (sel_wr && ws == 0) ws = n;
            if (sel_rd && rs == 0) rs = n;
            if (wr_ack) begin wa = n; wr_req = 0; end
            if (rd_ack) begin ra = n; rd_req = 0; end
        end
        wr_req = 0; rd_req = 0;
        last_m = !first_wr;
        ews = first_wr ? 1 : L + 2;
        ers = first_wr ? L + 2 : 1;
        total++; if (ws != ews) begin bad++; $display("FAIL tie_wr_start got=%0d exp=%0d", ws, ews); end
        total++; if (rs != ers) begin bad++; $display("FAIL tie_rd_start got=%0d exp=%0d", rs, ers); end
        total++; if (wa != ews + L - 1) begin bad++; $display("FAIL tie_wr_ack got=%0d exp=%0d", wa, ews + L - 1); end
        total++; if (ra != ers + L - 1) begin bad++; $display("FAIL tie_rd_ack got=%0d exp=%0d", ra, ers + L - 1); end
        @(negedge clk);
    endtask

    task automatic test_fairness();
        int gr[4] = '{default: -1};
        int ng = 0, nacks = 0;
        bit pw = 0, pr = 0, rw = 0, rr = 0, exp_w;
        do_reset();
        ad_in = 8'h3C;
        wr_req = 1; rd_req = 1;
        for (int n = 0; n < 120 && nacks < 4; n++) begin
            @(posedge clk); @(negedge clk);
            if (rw) begin wr_req = 1; rw = 0; end
            if (rr) begin rd_req = 1; rr = 0; end
            if (sel_wr && !pw && ng < 4) begin gr[ng] = 1; ng++; end
            if (sel_rd && !pr && ng < 4) begin gr[ng] = 0; ng++; end
            pw = sel_wr; pr = sel_rd;
            if (wr_ack) begin wr_req = 0; nacks++; rw = (nacks < 4); end
            if (rd_ack) begin rd_req = 0; nacks++; rr = (nacks < 4); end
        end
        wr_req = 0; rd_req = 0;
        for (int g = 0; g < 4; g++) begin
            exp_w = !last_m;
            last_m = exp_w;
            total++; if (gr[g] != (exp_w ? 1 : 0)) begin
                bad++; $display("FAIL fair_grant%0d got=%0d exp=%0d", g, gr[g], exp_w ? 1 : 0); end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        int lat = 0;
        wr_addr = 8'($urandom); wr_data = 8'($urandom); wr_req = 1;
        for (int i = 1; i <= 2*P + G - 2; i++) begin
            @(posedge clk); @(negedge clk);
        end
        total++; if ({rtc_wr_n, rtc_cs_n, rtc_ad} !== 3'b001) begin
            bad++; $display("FAIL mid_pre got=%b exp=001", {rtc_wr_n, rtc_cs_n, rtc_ad}); end
        rst_n = 0; wr_req = 0;
        #1;
        total++; if ({rtc_cs_n, rtc_wr_n, rtc_rd_n, ad_oe, busy, sel_wr, sel_rd, rd_data} !== {4'b1110, 3'b000, 8'h00}) begin
            bad++; $display("FAIL mid_reset got=%h exp=%h",
                {rtc_cs_n, rtc_wr_n, rtc_rd_n, ad_oe, busy, sel_wr, sel_rd, rd_data}, {4'b1110, 3'b000, 8'h00}); end
        @(negedge clk);
        rst_n = 1; last_m = 0;
        repeat (20) begin
            @(negedge clk);
            if (wr_ack || rd_ack) seen = 1;
        end
        total++; if (seen) begin bad++; $display("FAIL mid_noack got=1 exp=0"); end
        wr_req = 1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); @(negedge clk);
            if (wr_ack) begin lat = n; break; end
        end
        wr_req = 0; last_m = 1;
        total++; if (lat != L) begin bad++; $display("FAIL mid_rerun_lat got=%0d exp=%0d", lat, L); end
        @(negedge clk);
    endtask

    task automatic test_short();
        localparam int SL = 5;
        logic [7:0] vals[SL+1];
        logic [7:0] a;
        logic [14:0] e;
        repeat (2) begin
            a = 8'($urandom);
            rd_addr1 = a; rd_req1 = 1;
            ad_in1 = 8'($urandom); vals[0] = ad_in1;
            for (int i = 1; i <= SL; i++) begin
                @(posedge clk); @(negedge clk);
                e = bus_exp(i, 1'b0, a, 8'h00, 1, 1);
                total++; if (obs1 !== e) begin bad++; $display("FAIL short_bus c%0d got=%h exp=%h", i, obs1, e); end
                if (i == SL) begin
                    total++; if (rd_data1 !== vals[3]) begin
                        bad++; $display("FAIL short_data got=%h exp=%h", rd_data1, vals[3]); end
                    rd_req1 = 0;
                end
                ad_in1 = 8'($urandom); vals[i] = ad_in1;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [7:0] aw, dw, ar, vals[L+1];
        logic [14:0] e;
        int kind;
        bit ew;
        for (int t = 0; t < 24; t++) begin
            kind = $urandom_range(0, 2);
            aw = 8'($urandom); dw = 8'($urandom); ar = 8'($urandom);
            ew = (kind == 0) ? 1'b1 : (kind == 1) ? 1'b0 : !last_m;
            last_m = ew;
            wr_addr = aw; wr_data = dw; rd_addr = ar;
            wr_req = (kind != 1); rd_req = (kind != 0);
            ad_in = 8'($urandom); vals[0] = ad_in;
            for (int i = 1; i <= L; i++) begin
                @(posedge clk); @(negedge clk);
                if (i == 1) begin wr_addr = 8'($urandom); wr_data = 8'($urandom); rd_addr = 8'($urandom); end
                e = bus_exp(i, ew, ew ? aw : ar, dw, P, G);
                total++; if (obs !== e) begin bad++; $display("FAIL rand%0d_bus c%0d got=%h exp=%h", t, i, obs, e); end
                total++; if ({busy, sel_wr, sel_rd} !== {1'b1, ew, !ew}) begin
                    bad++; $display("FAIL rand%0d_sel c%0d got=%b exp=%b", t, i, {busy, sel_wr, sel_rd}, {1'b1, ew, !ew}); end
                if (i == L) begin
                    if (!ew) begin
                        total++; if (rd_data !== vals[2*P + G]) begin
                            bad++; $display("FAIL rand%0d_data got=%h exp=%h", t, rd_data, vals[2*P + G]); end
                    end
                    wr_req = 0; rd_req = 0;
                end
                ad_in = 8'($urandom); vals[i] = ad_in;
            end
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_tie();
        test_fairness();
        test_reset_mid();
        test_short();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
